boundary_probe_arbiter: RTL and testbench

//  Shares the single registered boundary-map lookup (x,y -> map, 1=walkable) among NREQ movers (player, enemies).

---
 rtl/boundary_pkg.sv | 46 ++++
 rtl/rr_arbiter.sv | 43 ++++
 rtl/boundary_probe_arbiter.sv | 225 ++++++++++++++++++++++
 tb/tb_boundary_probe_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/boundary_pkg.sv
// -----------------------------------------------------------------------------
// boundary_pkg
//   Shared types and constants for the boundary probe arbiter:
//   coordinate widths, default screen size, FSM state encoding,
//   corner index type, latency-alignment tag, corner arithmetic helper.
// -----------------------------------------------------------------------------
package boundary_pkg;

  localparam int COORD_W   = 7;            // OLED coordinate width (0..127)
  localparam int SUM_W     = COORD_W + 1;  // corner sums keep the carry
  localparam int DEF_SCR_W = 96;
  localparam int DEF_SCR_H = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PROBE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_ACK   = 2'd3
  } state_t;

  // Corner k: bit 0 selects the far x edge, bit 1 selects the far y edge.
  typedef logic [1:0] corner_t;

  localparam corner_t LAST_CORNER = 2'd3;

  // Travels alongside each lookup so its result is consumed exactly when the
  // map answers, MAP_LAT cycles after the corner was issued.
  typedef struct packed {
    logic valid;  // a corner result arrives this cycle
    logic last;   // it is the final corner of the transaction
    logic clip;   // corner lies outside the visible screen
  } probe_tag_t;

  // Base coordinate plus (span-1) on the far edge, computed one bit wider
  // than a coordinate so off-screen sums remain visible to the edge clip.
  function automatic logic [SUM_W-1:0] corner_sum(
    input logic [COORD_W-1:0] base,
    input logic               far_edge,
    input int unsigned        span
  );
    logic [SUM_W-1:0] offset;
    offset     = far_edge ? SUM_W'(span - 1) : '0;
    corner_sum = {1'b0, base} + offset;
  endfunction

endpackage : boundary_pkg

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin pick: the first asserted request at or after
//   the priority pointer, searching upward with wrap-around.
// Ports
//   i_req         in  NREQ           request vector
//   i_ptr         in  clog2(NREQ)    highest-priority index this round
//   o_grant_oh    out NREQ           one-hot grant (zero when no request)
//   o_grant_idx   out clog2(NREQ)    binary index of the grant
//   o_grant_valid out 1              any request present
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         i_req,
  input  logic [$clog2(NREQ)-1:0] i_ptr,
  output logic [NREQ-1:0]         o_grant_oh,
  output logic [$clog2(NREQ)-1:0] o_grant_idx,
  output logic                    o_grant_valid
);

  localparam int PTR_W = $clog2(NREQ);

  logic [PTR_W-1:0] w_idx;

  always_comb begin
    // NOTE: every output gets a default before any conditional assignment so
    // no path leaves a value unassigned, which would infer a latch.
    o_grant_oh    = '0;
    o_grant_idx   = '0;
    o_grant_valid = 1'b0;
    w_idx         = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_idx = PTR_W'((int'(i_ptr) + i) % NREQ);
      if (!o_grant_valid && i_req[w_idx]) begin
        o_grant_valid     = 1'b1;
        o_grant_idx       = w_idx;
        o_grant_oh[w_idx] = 1'b1;
      end
    end
  end

endmodule : rr_arbiter

// File: rtl/boundary_probe_arbiter.sv
// -----------------------------------------------------------------------------
// boundary_probe_arbiter
//   Shares one registered boundary-map lookup among NREQ movers. A request is
//   a sprite top-left position; the block probes the four footprint corners
//   and returns a single blocked flag (1 = some corner not walkable).
//
//   FSM: IDLE -> PROBE (4 corners) -> DRAIN (MAP_LAT cycles) -> ACK -> IDLE
//   Latency: req seen in cycle T -> ack in cycle T+5+MAP_LAT.
//
// Configuration macro
//   BOUNDARY_EDGE_CLIP_EN  corners with x>=SCR_W or y>=SCR_H (8-bit sums)
//                          count as blocked regardless of map_in. Without it
//                          coordinates wrap at 128 and map_in alone decides.
//
// Ports
//   clk50    in   1          system clock, rising edge
//   rst      in   1          asynchronous active-high reset
//   req      in   NREQ       per-requester probe request, held until ack
//   req_x    in   NREQ*7     packed top-left x, requester i at [7i+6:7i]
//   req_y    in   NREQ*7     packed top-left y, same packing
//   ack      out  NREQ       one-cycle pulse to the served requester
//   blocked  out  1          result, valid only in the ack cycle
//   busy     out  1          high from grant through the ack cycle
//   map_x    out  7          lookup x to boundary map
//   map_y    out  7          lookup y to boundary map
//   map_in   in   1          boundary map result (1 = walkable)
// -----------------------------------------------------------------------------
module boundary_probe_arbiter
  import boundary_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int SPR_W   = 3,
  parameter int SPR_H   = 3,
  parameter int MAP_LAT = 1,
  parameter int SCR_W   = DEF_SCR_W,
  parameter int SCR_H   = DEF_SCR_H
) (
  input  logic                    clk50,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*COORD_W-1:0] req_x,
  input  logic [NREQ*COORD_W-1:0] req_y,
  output logic [NREQ-1:0]         ack,
  output logic                    blocked,
  output logic                    busy,
  output logic [COORD_W-1:0]      map_x,
  output logic [COORD_W-1:0]      map_y,
  input  logic                    map_in
);

  localparam int PTR_W = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8 || SPR_W < 1 || SPR_H < 1 || MAP_LAT < 1 ||
      SCR_W > 128 || SCR_H > 128) begin : g_bad_cfg
    $error("boundary_probe_arbiter: unsupported parameter combination");
  end

  // ---------------------------------------------------------------------------
  // Registers and wires
  // ---------------------------------------------------------------------------
  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [PTR_W-1:0]       r_rr;
  logic [PTR_W-1:0]       r_grant_idx;
  logic [NREQ-1:0]        r_grant_oh;
  logic [COORD_W-1:0]     r_x;
  logic [COORD_W-1:0]     r_y;
  corner_t                r_corner;
  logic                   r_acc;
  probe_tag_t [MAP_LAT-1:0] r_pipe;

  logic [NREQ-1:0]        w_grant_oh;
  logic [PTR_W-1:0]       w_grant_idx;
  logic                   w_grant_valid;
  logic [COORD_W-1:0]     w_sel_x;
  logic [COORD_W-1:0]     w_sel_y;
  logic [COORD_W-1:0]     w_corner_x;
  logic [COORD_W-1:0]     w_corner_y;
  logic                   w_clip;
  logic                   w_issue;
  probe_tag_t             w_tag_in;
  probe_tag_t             w_tag_out;
  logic                   w_grant_take;

  // ---------------------------------------------------------------------------
  // Round-robin selection and request coordinate mux
  // ---------------------------------------------------------------------------
  rr_arbiter #(
    .NREQ (NREQ)
  ) u_rr_arbiter (
    .i_req         (req),
    .i_ptr         (r_rr),
    .o_grant_oh    (w_grant_oh),
    .o_grant_idx   (w_grant_idx),
    .o_grant_valid (w_grant_valid)
  );

  always_comb begin
    w_sel_x = '0;
    w_sel_y = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant_oh[i]) begin
        w_sel_x = req_x[i*COORD_W +: COORD_W];
        w_sel_y = req_y[i*COORD_W +: COORD_W];
      end
    end
  end

  assign w_grant_take = (r_state == ST_IDLE) && w_grant_valid;

  // ---------------------------------------------------------------------------
  // Corner coordinates and optional screen-edge clip
  // ---------------------------------------------------------------------------
`ifdef BOUNDARY_EDGE_CLIP_EN
  logic [SUM_W-1:0] w_sum_x;
  logic [SUM_W-1:0] w_sum_y;

  assign w_sum_x    = corner_sum(r_x, r_corner[0], SPR_W);
  assign w_sum_y    = corner_sum(r_y, r_corner[1], SPR_H);
  assign w_corner_x = w_sum_x[COORD_W-1:0];
  assign w_corner_y = w_sum_y[COORD_W-1:0];
  assign w_clip     = (w_sum_x >= SUM_W'(SCR_W)) || (w_sum_y >= SUM_W'(SCR_H));
`else
  // The lookup address is the low 7 bits of the 8-bit sum, i.e. it wraps.
  assign w_corner_x = COORD_W'(corner_sum(r_x, r_corner[0], SPR_W));
  assign w_corner_y = COORD_W'(corner_sum(r_y, r_corner[1], SPR_H));
  assign w_clip     = 1'b0;
`endif

  assign w_tag_in  = '{valid: w_issue, last: (r_corner == LAST_CORNER), clip: w_clip};
  assign w_tag_out = r_pipe[MAP_LAT-1];

  // ---------------------------------------------------------------------------
  // FSM next state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    busy        = 1'b0;
    ack         = '0;
    blocked     = 1'b0;
    map_x       = '0;
    map_y       = '0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_grant_valid) w_state_nxt = ST_PROBE;
      end
      ST_PROBE: begin
        busy    = 1'b1;
        w_issue = 1'b1;
        map_x   = w_corner_x;
        map_y   = w_corner_y;
        if (r_corner == LAST_CORNER) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        // r_corner rests on the last corner, so the address stays stable.
        busy  = 1'b1;
        map_x = w_corner_x;
        map_y = w_corner_y;
        if (w_tag_out.valid && w_tag_out.last) w_state_nxt = ST_ACK;
      end
      ST_ACK: begin
        busy        = 1'b1;
        map_x       = w_corner_x;
        map_y       = w_corner_y;
        ack         = r_grant_oh;
        blocked     = r_acc;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement or process order.
  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) begin
      r_rr        <= '0;
      r_grant_idx <= '0;
      r_grant_oh  <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_corner    <= '0;
      r_acc       <= 1'b0;
      // NOTE: the tag pipeline is reset like control state, not left as
      // uninitialised storage: a stale valid tag surviving a mid-transaction
      // reset would fold a dead lookup into the next probe.
      r_pipe      <= '0;
    end else begin
      for (int i = MAP_LAT - 1; i > 0; i--) r_pipe[i] <= r_pipe[i-1];
      r_pipe[0] <= w_tag_in;

      if (w_grant_take) begin
        r_grant_idx <= w_grant_idx;
        r_grant_oh  <= w_grant_oh;
        r_x         <= w_sel_x;
        r_y         <= w_sel_y;
        r_corner    <= '0;
        r_acc       <= 1'b0;
      end else if (w_tag_out.valid) begin
        r_acc <= r_acc | ~map_in | w_tag_out.clip;
      end

      if (r_state == ST_PROBE && r_corner != LAST_CORNER) begin
        r_corner <= r_corner + corner_t'(1);
      end

      if (r_state == ST_ACK) begin
        r_rr <= (r_grant_idx == PTR_W'(NREQ - 1)) ? '0 : r_grant_idx + PTR_W'(1);
      end
    end
  end

endmodule : boundary_probe_arbiter

// File: tb/tb_boundary_probe_arbiter.sv
// -----------------------------------------------------------------------------
// tb_boundary_probe_arbiter
//   Directed bench for boundary_probe_arbiter with a behavioural boundary map
//   (single configurable non-walkable cell, MAP_LAT-cycle registered lookup).
// -----------------------------------------------------------------------------
module tb_boundary_probe_arbiter;

  localparam int NREQ    = 4;
  localparam int SPR_W   = 3;
  localparam int SPR_H   = 3;
  localparam int MAP_LAT = 1;
  localparam int LAT     = 5 + MAP_LAT;   // req cycle to ack cycle
  localparam int PERIOD  = 6 + MAP_LAT;   // ack-to-ack spacing under load
`ifdef BOUNDARY_EDGE_CLIP_EN
  localparam logic CLIP = 1'b1;
`else
  localparam logic CLIP = 1'b0;
`endif

  logic              clk50 = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ*7-1:0] req_x;
  logic [NREQ*7-1:0] req_y;
  logic [NREQ-1:0]   ack;
  logic              blocked;
  logic              busy;
  logic [6:0]        map_x;
  logic [6:0]        map_y;
  logic              map_in;

  always #10 clk50 = ~clk50;

  boundary_probe_arbiter #(
    .NREQ    (NREQ),
    .SPR_W   (SPR_W),
    .SPR_H   (SPR_H),
    .MAP_LAT (MAP_LAT)
  ) dut (
    .clk50   (clk50),
    .rst     (rst),
    .req     (req),
    .req_x   (req_x),
    .req_y   (req_y),
    .ack     (ack),
    .blocked (blocked),
    .busy    (busy),
    .map_x   (map_x),
    .map_y   (map_y),
    .map_in  (map_in)
  );

  // Boundary map model: walkable everywhere except (blk_x, blk_y) when enabled.
  logic       blk_en;
  logic [6:0] blk_x;
  logic [6:0] blk_y;
  logic [6:0] mx_d [MAP_LAT];
  logic [6:0] my_d [MAP_LAT];

  always_ff @(posedge clk50) begin
    mx_d[0] <= map_x;
    my_d[0] <= map_y;
    for (int i = 1; i < MAP_LAT; i++) begin
      mx_d[i] <= mx_d[i-1];
      my_d[i] <= my_d[i-1];
    end
  end

  assign map_in = ~(blk_en && mx_d[MAP_LAT-1] == blk_x && my_d[MAP_LAT-1] == blk_y);

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  logic [6:0] tr_x [0:31];
  logic [6:0] tr_y [0:31];

  // Raise req[idx] with a position, wait (bounded) for the ack, then drop req
  // and let the FSM return to IDLE.
  task automatic do_req(input int idx, input logic [6:0] x, input logic [6:0] y,
                        output int lat, output logic [NREQ-1:0] ackv,
                        output logic blk, output int busy_n);
    int n;
    bit done;
    req_x[idx*7 +: 7] = x;
    req_y[idx*7 +: 7] = y;
    req[idx] = 1'b1;
    lat = -1; ackv = '0; blk = 1'b0; busy_n = 0; n = 0; done = 1'b0;
    while (!done && n < 30) begin
      @(posedge clk50); #1;
      n++;
      tr_x[n] = map_x;
      tr_y[n] = map_y;
      if (busy) busy_n++;
      if (ack != '0) begin
        done = 1'b1; lat = n; ackv = ack; blk = blocked;
      end
    end
    req[idx] = 1'b0;
    @(posedge clk50); #1;
  endtask

  int              lat;
  int              busy_n;
  logic [NREQ-1:0] ackv;
  logic            blk;

  initial begin
    rst = 1'b1; req = '0; req_x = '0; req_y = '0;
    blk_en = 1'b0; blk_x = '0; blk_y = '0;
    repeat (2) @(posedge clk50);
    #1;
    check("rst_ack",     ack,     0);
    check("rst_blocked", blocked, 0);
    check("rst_busy",    busy,    0);
    check("rst_map_x",   map_x,   0);
    check("rst_map_y",   map_y,   0);
    rst = 1'b0;
    @(posedge clk50); #1;

    // 1: single request, all walkable; corner sequence and timing.
    do_req(0, 7'd40, 7'd20, lat, ackv, blk, busy_n);
    check("t1_latency", lat,    LAT);
    check("t1_ack",     ackv,   4'b0001);
    check("t1_blocked", blk,    0);
    check("t1_busy_n",  busy_n, LAT);
    check("t1_c0_x", tr_x[1], 40); check("t1_c0_y", tr_y[1], 20);
    check("t1_c1_x", tr_x[2], 42); check("t1_c1_y", tr_y[2], 20);
    check("t1_c2_x", tr_x[3], 40); check("t1_c2_y", tr_y[3], 22);
    check("t1_c3_x", tr_x[4], 42); check("t1_c3_y", tr_y[4], 22);
    check("t1_ack_hold_x", tr_x[LAT], 42);
    check("t1_idle_map_x", map_x, 0);
    check("t1_idle_busy",  busy,  0);

    // 2: only corner 3 blocked; rr pointer now 1.
    blk_en = 1'b1; blk_x = 7'd42; blk_y = 7'd22;
    do_req(1, 7'd40, 7'd20, lat, ackv, blk, busy_n);
    check("t2_latency", lat,  LAT);
    check("t2_ack",     ackv, 4'b0010);
    check("t2_blocked", blk,  1);

    // Corner 0 blocked, requester 3.
    blk_x = 7'd40; blk_y = 7'd20;
    do_req(3, 7'd40, 7'd20, lat, ackv, blk, busy_n);
    check("t2b_ack",     ackv, 4'b1000);
    check("t2b_blocked", blk,  1);

    // Wrap: corner 1 of x=126 lands on x=0 (or is clipped off-screen).
    blk_x = 7'd0; blk_y = 7'd0;
    do_req(2, 7'd126, 7'd0, lat, ackv, blk, busy_n);
    check("wrap_ack",     ackv, 4'b0100);
    check("wrap_blocked", blk,  1);
    check("wrap_c1_x",    tr_x[2], 0);

    // Latched position: req dropped and moved after grant; old spot is probed.
    blk_x = 7'd12; blk_y = 7'd12;
    req_x[6:0] = 7'd10; req_y[6:0] = 7'd10; req[0] = 1'b1;
    @(posedge clk50); #1;
    @(posedge clk50); #1;
    req[0] = 1'b0; req_x[6:0] = 7'd50; req_y[6:0] = 7'd50;
    lat = -1; ackv = '0; blk = 1'b0;
    for (int n = 3; n <= 30 && lat < 0; n++) begin
      @(posedge clk50); #1;
      if (ack != '0) begin lat = n; ackv = ack; blk = blocked; end
    end
    check("latch_latency", lat,  LAT);
    check("latch_ack",     ackv, 4'b0001);
    check("latch_blocked", blk,  1);
    @(posedge clk50); #1;

    // 5: edge clip at the right screen edge, map walkable.
    blk_en = 1'b0;
    do_req(0, 7'd94, 7'd10, lat, ackv, blk, busy_n);
    check("clip_ack",     ackv, 4'b0001);
    check("clip_blocked", blk,  CLIP);
    do_req(1, 7'd93, 7'd61, lat, ackv, blk, busy_n);
    check("edge_in_ack",     ackv, 4'b0010);
    check("edge_in_blocked", blk,  0);

    // 3: all four held after reset -> 0,1,2,3,0, single-cycle, fixed spacing.
    rst = 1'b1;
    @(posedge clk50); #1;
    rst = 1'b0;
    begin
      int cyc;
      int prev;
      int at;
      cyc = 0; prev = -1;
      req = 4'hF;
      for (int k = 0; k < 5; k++) begin
        at = -1; ackv = '0;
        for (int w = 0; w < 20 && at < 0; w++) begin
          @(posedge clk50); #1;
          cyc++;
          if (ack != '0) begin at = cyc; ackv = ack; end
        end
        check("rr_ack_order", ackv, 32'(1 << (k % NREQ)));
        if (k > 0) check("rr_spacing", at - prev, PERIOD);
        prev = at;
        @(posedge clk50); #1;
        cyc++;
        check("rr_ack_pulse", ack,  0);
        check("rr_idle_busy", busy, 0);
        if (k == 4) req = '0;
      end
    end

    // 4: reset during corner 2, then normal service from a cleared pointer.
    req_x[13:7] = 7'd40; req_y[13:7] = 7'd20; req[1] = 1'b1;
    repeat (3) begin @(posedge clk50); #1; end
    check("t4_c2_x",  map_x, 40);
    check("t4_c2_y",  map_y, 22);
    check("t4_busy",  busy,  1);
    rst = 1'b1; req = '0;
    #1;
    check("t4_async_busy",  busy,  0);
    check("t4_async_map_y", map_y, 0);
    @(posedge clk50); #1;
    check("t4_rst_ack",     ack,     0);
    check("t4_rst_blocked", blocked, 0);
    check("t4_rst_map_x",   map_x,   0);
    rst = 1'b0;
    begin
      int acks;
      acks = 0;
      repeat (10) begin
        @(posedge clk50); #1;
        if (ack != '0) acks++;
      end
      check("t4_no_ack", acks, 0);
    end
    do_req(2, 7'd5, 7'd5, lat, ackv, blk, busy_n);
    check("t4_after_latency", lat,  LAT);
    check("t4_after_ack",     ackv, 4'b0100);
    check("t4_after_blocked", blk,  0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_boundary_probe_arbiter
